// File: rtl/transmit_packet_if.sv
// Command, packet-RAM read-master and MAC TX stream signals of the transmit path.
// master = transmit_packet side, slave = CPU/RAM/MAC side.
interface transmit_packet_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 12
);
    logic              tx_start;
    logic [ADDR_W-1:0] tx_base;
    logic [LEN_W-1:0]  tx_len;
    logic              tx_busy;
    logic              tx_done;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_chipselect;
    logic              ram_read;
    logic [31:0]       ram_readdata;
    logic [3:0]        ram_byteenable;
    logic              ram_waitrequest;

    logic [7:0]        ff_tx_data;
    logic              ff_tx_sop;
    logic              ff_tx_eop;
    logic              ff_tx_wren;
    logic              ff_tx_rdy;
    logic              ff_tx_err;
    logic              ff_tx_crc_fwd;

    modport master (
        input  tx_start, tx_base, tx_len, ram_readdata, ram_waitrequest, ff_tx_rdy,
        output tx_busy, tx_done, ram_addr, ram_chipselect, ram_read, ram_byteenable,
               ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_err, ff_tx_crc_fwd
    );

    modport slave (
        output tx_start, tx_base, tx_len, ram_readdata, ram_waitrequest, ff_tx_rdy,
        input  tx_busy, tx_done, ram_addr, ram_chipselect, ram_read, ram_byteenable,
               ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_err, ff_tx_crc_fwd
    );
endinterface

// File: rtl/transmit_packet.sv
// Reads a packet of little-endian words from RAM and streams it byte-wise to the MAC TX FIFO.
// First byte 2+READ_LATENCY cycles after start; ff_tx_rdy low holds the byte, ram_waitrequest holds the read.
module transmit_packet #(
    parameter int ADDR_W       = 10,
    parameter int LEN_W        = 12,
    parameter int READ_LATENCY = 1
) (
    input logic               clk_original,
    input logic               rst,
    transmit_packet_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t                  r_state;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_read;
    logic [READ_LATENCY-1:0] r_lat;
    logic [LEN_W-2:0]        r_words_left;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        r_sent;
    logic [31:0]             r_cur;
    logic [31:0]             r_pf;
    logic                    r_cur_vld;
    logic                    r_pf_vld;
    logic [7:0]              r_data;
    logic                    r_sop;
    logic                    r_eop;
    logic                    r_wren;
    logic                    r_busy;
    logic                    r_done;

    logic             w_accept;
    logic             w_rd_vld;
    logic             w_lat_early;
    logic             w_xfer;
    logic             w_out_free;
    logic             w_active;
    logic             w_src_vld;
    logic             w_load;
    logic             w_word_end;
    logic             w_issue;
    logic [1:0]       w_lane;
    logic [31:0]      w_src;
    logic [31:0]      w_cur_n;
    logic [31:0]      w_pf_n;
    logic             w_cur_vld_n;
    logic             w_pf_vld_n;
    logic [LEN_W-2:0] w_nwords;

    assign w_accept    = r_read && !bus.ram_waitrequest;
    assign w_rd_vld    = r_lat[READ_LATENCY-1];
    assign w_lat_early = |(r_lat << 1);
    assign w_xfer      = r_wren && bus.ff_tx_rdy;
    assign w_out_free  = !r_wren || bus.ff_tx_rdy;
    assign w_active    = (r_state == FETCH) || (r_state == SEND);
    // An empty word buffer lets arriving read data feed the output byte directly.
    assign w_src_vld   = r_cur_vld || w_rd_vld;
    assign w_src       = r_cur_vld ? r_cur : bus.ram_readdata;
    assign w_lane      = r_sent[1:0];
    assign w_load      = w_active && w_out_free && w_src_vld && (r_sent != r_len);
    assign w_word_end  = (w_lane == 2'd3) || (r_sent == r_len - LEN_W'(1));
    assign w_nwords    = (LEN_W-1)'(({1'b0, bus.tx_len} + (LEN_W+1)'(3)) >> 2);

    always_comb begin
        w_cur_n     = r_cur;
        w_cur_vld_n = r_cur_vld;
        w_pf_n      = r_pf;
        w_pf_vld_n  = r_pf_vld;
        if (w_load && w_word_end && r_cur_vld) begin
            if (r_pf_vld) begin
                w_cur_n    = r_pf;
                w_pf_n     = bus.ram_readdata;
                w_pf_vld_n = w_rd_vld;
            end else begin
                w_cur_n     = bus.ram_readdata;
                w_cur_vld_n = w_rd_vld;
            end
        end else if (w_load && w_word_end) begin
            w_cur_vld_n = 1'b0;
        end else if (w_rd_vld) begin
            if (!r_cur_vld) begin
                w_cur_n     = bus.ram_readdata;
                w_cur_vld_n = 1'b1;
            end else begin
                w_pf_n     = bus.ram_readdata;
                w_pf_vld_n = 1'b1;
            end
        end
    end

    // Only one read in flight, and only while the prefetch slot will be free to take it.
    assign w_issue = w_active && !r_read && !w_lat_early && (r_words_left != '0) && !w_pf_vld_n;

    always_ff @(posedge clk_original or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_read       <= 1'b0;
            r_lat        <= '0;
            r_words_left <= '0;
            r_len        <= '0;
            r_sent       <= '0;
            r_cur        <= '0;
            r_pf         <= '0;
            r_cur_vld    <= 1'b0;
            r_pf_vld     <= 1'b0;
            r_data       <= '0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_wren       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_lat     <= (r_lat << 1) | READ_LATENCY'(w_accept);
            r_cur     <= w_cur_n;
            r_cur_vld <= w_cur_vld_n;
            r_pf      <= w_pf_n;
            r_pf_vld  <= w_pf_vld_n;

            if (w_accept) begin
                r_read <= 1'b0;
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_issue) begin
                r_read       <= 1'b1;
                r_words_left <= r_words_left - (LEN_W-1)'(1);
            end

            if (w_load) begin
                r_data <= w_src[{w_lane, 3'b000} +: 8];
                r_sop  <= (r_sent == '0);
                r_eop  <= (r_sent == r_len - LEN_W'(1));
                r_wren <= 1'b1;
                r_sent <= r_sent + LEN_W'(1);
            end else if (w_out_free) begin
                r_data <= '0;
                r_sop  <= 1'b0;
                r_eop  <= 1'b0;
                r_wren <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (bus.tx_start && (bus.tx_len != '0)) begin
                        r_state      <= FETCH;
                        r_busy       <= 1'b1;
                        r_addr       <= bus.tx_base;
                        r_read       <= 1'b1;
                        r_len        <= bus.tx_len;
                        r_sent       <= '0;
                        r_words_left <= w_nwords - (LEN_W-1)'(1);
                        r_cur_vld    <= 1'b0;
                        r_pf_vld     <= 1'b0;
                    end
                end
                FETCH: begin
                    if (w_rd_vld) r_state <= SEND;
                end
                SEND: begin
                    if (w_xfer && r_eop) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.tx_busy        = r_busy;
    assign bus.tx_done        = r_done;
    assign bus.ram_addr       = r_addr;
    assign bus.ram_chipselect = r_read;
    assign bus.ram_read       = r_read;
    assign bus.ram_byteenable = 4'hF;
    assign bus.ff_tx_data     = r_data;
    assign bus.ff_tx_sop      = r_sop;
    assign bus.ff_tx_eop      = r_eop;
    assign bus.ff_tx_wren     = r_wren;
    assign bus.ff_tx_err      = 1'b0;
    assign bus.ff_tx_crc_fwd  = 1'b0;
endmodule

// File: tb/tb_transmit_packet.sv
// Scoreboard bench for transmit_packet: stimulus queues expected bytes/read addresses, a monitor pops and compares.
`timescale 1ns/1ps
module tb_transmit_packet;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    transmit_packet_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    transmit_packet #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .READ_LATENCY(1)) dut (
        .clk_original (clk),
        .rst          (rst_n),
        .bus          (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int start_cyc = 0, sop_cyc = 0, eop_cyc = 0;
    int acc_cnt = 0, served_cnt = 0, wcnt = 0;
    logic wait_mode = 1'b0;
    logic toggle_mode = 1'b0;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0] mem [0:1023];
    logic [9:0] exp_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    logic prev_stall = 1'b0;
    logic prev_eop_xfer = 1'b0;
    logic [9:0] prev_out = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got 0x%0h, nothing expected", name, act);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RAM slave (one-cycle read latency), wait-state generator and sink-ready driver.
    always @(posedge clk) begin
        #1;
        if (acc_cnt != served_cnt) begin
            bus.ram_readdata = mem[acc_addr];
            served_cnt = acc_cnt;
        end
        if (bus.ram_read && wait_mode && wcnt < 3) begin
            bus.ram_waitrequest = 1'b1;
            wcnt++;
        end else begin
            bus.ram_waitrequest = 1'b0;
            wcnt = 0;
        end
        bus.ff_tx_rdy = toggle_mode ? !bus.ff_tx_rdy : 1'b1;
    end

    always @(negedge clk) begin
        logic [9:0] cur;
        cur = {bus.ff_tx_data, bus.ff_tx_sop, bus.ff_tx_eop};
        if (prev_stall) check("hold_during_stall", {bus.ff_tx_wren, cur}, {1'b1, prev_out});
        prev_stall = bus.ff_tx_wren && !bus.ff_tx_rdy;
        prev_out = cur;
        if (bus.tx_done) begin
            done_cnt++;
            check("done_after_eop_busy_low", {prev_eop_xfer, bus.tx_busy}, 2'b10);
        end
        prev_eop_xfer = 1'b0;
        if (bus.ff_tx_wren && bus.ff_tx_rdy) begin
            if (exp_q.size() == 0) fail("unexpected_byte", cur);
            else check("tx_byte", cur, exp_q.pop_front());
            if (bus.ff_tx_sop) sop_cyc = cyc;
            if (bus.ff_tx_eop) begin
                eop_cyc = cyc;
                prev_eop_xfer = 1'b1;
            end
        end
        if (bus.ram_read && !bus.ram_waitrequest) begin
            if (addr_q.size() == 0) fail("unexpected_read", bus.ram_addr);
            else check("read_addr", bus.ram_addr, addr_q.pop_front());
            acc_addr = bus.ram_addr;
            acc_cnt++;
        end
    end

    task automatic start_pkt(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
        @(posedge clk); #1;
        bus.tx_start = 1'b1;
        bus.tx_base  = base;
        bus.tx_len   = len;
        start_cyc    = cyc;
        @(posedge clk); #1;
        bus.tx_start = 1'b0;
    endtask

    task automatic expect_pkt(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({bytes[8*i +: 8], (i == 0), (i == n - 1)});
    endtask

    task automatic wait_done(input int exp_cnt, input string name);
        for (int i = 0; i < 300 && done_cnt < exp_cnt; i++) @(negedge clk);
        check(name, done_cnt, exp_cnt);
        repeat (3) @(negedge clk);
        check({name, "_bytes_left"}, exp_q.size(), 0);
        check({name, "_reads_left"}, addr_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {bus.tx_busy, bus.tx_done, bus.ram_addr, bus.ram_chipselect, bus.ram_read,
                     bus.ff_tx_data, bus.ff_tx_sop, bus.ff_tx_eop, bus.ff_tx_wren,
                     bus.ff_tx_err, bus.ff_tx_crc_fwd}, 64'h0);
        check({name, "_byteenable"}, bus.ram_byteenable, 4'hF);
    endtask

    initial begin
        bus.tx_start = 1'b0;
        bus.tx_base  = '0;
        bus.tx_len   = '0;
        mem[10'h010] = 32'h44332211;
        mem[10'h011] = 32'h88776655;
        mem[10'h012] = 32'hCAFEF00D;
        mem[10'h3FF] = 32'hDDCCBBAA;
        mem[10'h000] = 32'h04030201;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        rst_n = 1'b1;

        // 8 bytes, gapless, two reads
        addr_q.push_back(10'h010); addr_q.push_back(10'h011);
        expect_pkt(64'h8877665544332211, 8);
        start_pkt(10'h010, 12'd8);
        check("s1_busy_after_start", bus.tx_busy, 1'b1);
        wait_done(1, "s1_done");
        check("s1_first_byte_latency", sop_cyc - start_cyc, 3);
        check("s1_gapless", eop_cyc - sop_cyc, 7);

        // partial final word
        addr_q.push_back(10'h010); addr_q.push_back(10'h011);
        expect_pkt(64'h0000005544332211, 5);
        start_pkt(10'h010, 12'd5);
        wait_done(2, "s2_done");
        check("s2_gapless", eop_cyc - sop_cyc, 4);

        // single byte
        addr_q.push_back(10'h010);
        expect_pkt(64'h0000000000000011, 1);
        start_pkt(10'h010, 12'd1);
        wait_done(3, "s3_done");
        check("s3_first_byte_latency", sop_cyc - start_cyc, 3);

        // address wrap
        addr_q.push_back(10'h3FF); addr_q.push_back(10'h000);
        expect_pkt(64'h04030201DDCCBBAA, 8);
        start_pkt(10'h3FF, 12'd8);
        wait_done(4, "s4_done");

        // sink stalls every other cycle, 3 wait states per read
        wait_mode = 1'b1; toggle_mode = 1'b1;
        addr_q.push_back(10'h010); addr_q.push_back(10'h011);
        expect_pkt(64'h8877665544332211, 8);
        start_pkt(10'h010, 12'd8);
        wait_done(5, "s5_done");
        wait_mode = 1'b0; toggle_mode = 1'b0;

        // start while busy is ignored
        addr_q.push_back(10'h010); addr_q.push_back(10'h011);
        expect_pkt(64'h8877665544332211, 8);
        start_pkt(10'h010, 12'd8);
        start_pkt(10'h3FF, 12'd4);
        wait_done(6, "s6_done");
        repeat (10) @(negedge clk);
        check("s6_no_extra_done", done_cnt, 6);

        // zero-length start is ignored
        start_pkt(10'h010, 12'd0);
        repeat (10) @(negedge clk);
        check("s7_len0_busy", bus.tx_busy, 1'b0);
        check("s7_len0_no_done", done_cnt, 6);

        // reset mid-packet truncates silently
        addr_q.push_back(10'h010); addr_q.push_back(10'h011);
        expect_pkt(64'h8877665544332211, 8);
        start_pkt(10'h010, 12'd8);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        addr_q.delete();
        #1;
        check_outputs_zero("s8_reset_outputs");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("s8_no_done_on_reset", done_cnt, 6);

        // clean packet after reset
        addr_q.push_back(10'h010); addr_q.push_back(10'h011);
        expect_pkt(64'h8877665544332211, 8);
        start_pkt(10'h010, 12'd8);
        wait_done(7, "s9_done");
        check("s9_first_byte_latency", sop_cyc - start_cyc, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
